// File: rtl/pcie_rx_pkg.sv
// Shared constants and types for the PCIe RX TLP demux: TLP fmt/type codes,
// rx_tuser field positions, FSM state and routing enums, and the classifier.
package pcie_rx_pkg;

   // rx_tuser layout from the PCIe core
   localparam int TUSER_W       = 22;
   localparam int TUSER_ERR_FWD = 1;
   localparam int TUSER_BAR_LSB = 2;
   localparam int BAR_W         = 7;
   localparam int TUSER_BAR_MSB = TUSER_BAR_LSB + BAR_W - 1;

   // {fmt[2:0], type[4:0]} codes taken from DW0[31:24]
   localparam logic [7:0] MRD32 = 8'b000_00000;
   localparam logic [7:0] MRD64 = 8'b001_00000;
   localparam logic [7:0] MWR32 = 8'b010_00000;
   localparam logic [7:0] MWR64 = 8'b011_00000;
   localparam logic [7:0] CPL   = 8'b000_01010;
   localparam logic [7:0] CPLD  = 8'b010_01010;

   typedef enum logic [1:0] {IDLE, FWD_REQ, FWD_CPL, DROP} state_t;
   typedef enum logic [1:0] {ROUTE_REQ, ROUTE_CPL, ROUTE_DROP} route_t;

   // Destination of a TLP given its first-beat fmt/type and poison flag.
   function automatic route_t classify(input logic [7:0] fmt_type, input logic err_fwd);
      route_t r;
      case (fmt_type)
         MRD32, MRD64, MWR32, MWR64: r = ROUTE_REQ;
         CPL, CPLD:                  r = ROUTE_CPL;
         default:                    r = ROUTE_DROP;
      endcase
      if (err_fwd) r = ROUTE_DROP;
      return r;
   endfunction

   // A TLP without data (fmt[1]=0) expects a completion, except messages
   // (type 10rrr), which are posted even when they carry no data.
   function automatic logic is_non_posted(input logic [7:0] fmt_type);
      return !fmt_type[6] && (fmt_type[4:3] != 2'b10);
   endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI4-Stream skid buffer. The head entry drives the outputs
// directly and in_ready_o is a flop, so no combinational path runs from
// out_ready_i back to the producer.
module axis_skid_buf #(
   parameter int WIDTH = 73
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic             ready_q;
   logic             push, pop;

   assign push        = in_valid_i && ready_q;
   assign pop         = (count_q != 2'd0) && out_ready_i;
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = head_q;
   assign in_ready_o  = ready_q;

   // Next occupancy and entry contents for the push/pop combination.
   always_comb begin
      // NOTE: every _d starts from its _q value so no branch leaves it unassigned, which would infer a latch.
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = in_data_i;
            else                 tail_d = in_data_i;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged; the incoming beat lands behind whatever remains.
            if (count_q == 2'd1) begin
               head_d = in_data_i;
            end else begin
               head_d = tail_q;
               tail_d = in_data_i;
            end
         end
         default: ;
      endcase
   end

   // Entry registers, occupancy and the registered ready.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: the payload is reset only because the output data must read 0 out of reset; pure storage would not need it.
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
         ready_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ready_q <= (count_d <= 2'd1);
      end
   end

endmodule

// File: rtl/pcie_rx_tlp_demux.sv
// Receive-side TLP steering: classifies each TLP on its first beat and forwards
// memory requests to the REQ stream, completions to the CPL stream, and drops
// everything else, flagging dropped non-posted requests on ur_pulse.
module pcie_rx_tlp_demux
   import pcie_rx_pkg::*;
#(
   parameter int C_DATA_WIDTH = 64,
   parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
   input  logic                    user_clk,
   input  logic                    user_reset,

   input  logic [C_DATA_WIDTH-1:0] rx_tdata,
   input  logic [KEEP_WIDTH-1:0]   rx_tkeep,
   input  logic                    rx_tlast,
   input  logic                    rx_tvalid,
   output logic                    rx_tready,
   input  logic [TUSER_W-1:0]      rx_tuser,

   output logic [C_DATA_WIDTH-1:0] req_tdata,
   output logic [KEEP_WIDTH-1:0]   req_tkeep,
   output logic                    req_tlast,
   output logic                    req_tvalid,
   input  logic                    req_tready,
   output logic [BAR_W-1:0]        req_bar,

   output logic [C_DATA_WIDTH-1:0] cpl_tdata,
   output logic [KEEP_WIDTH-1:0]   cpl_tkeep,
   output logic                    cpl_tlast,
   output logic                    cpl_tvalid,
   input  logic                    cpl_tready,

   output logic                    ur_pulse,
   output logic [15:0]             drop_count
);

   localparam int CPL_W = C_DATA_WIDTH + KEEP_WIDTH + 1;
   localparam int REQ_W = CPL_W + BAR_W;

   state_t           state_q, state_d;
   route_t           sop_route, route;
   logic             run_q;
   logic             sel_ready;
   logic             hs, sop_accept, drop_sop;
   logic             req_push, cpl_push;
   logic             req_in_ready, cpl_in_ready;
   logic [BAR_W-1:0] bar_q, beat_bar;
   logic             ur_q;
   logic [15:0]      drop_count_q;
   logic [REQ_W-1:0] req_payload;
   logic [CPL_W-1:0] cpl_payload;
   logic             unused_tuser;

   assign sop_route  = classify(rx_tdata[31:24], rx_tuser[TUSER_ERR_FWD]);
   assign sop_accept = hs && (state_q == IDLE);
   assign drop_sop   = sop_accept && (route == ROUTE_DROP);
   assign req_push   = hs && (route == ROUTE_REQ);
   assign cpl_push   = hs && (route == ROUTE_CPL);
   // The BAR hit is only valid on the first beat; later beats reuse the latched copy.
   assign beat_bar   = (state_q == IDLE) ? rx_tuser[TUSER_BAR_MSB:TUSER_BAR_LSB] : bar_q;
   assign unused_tuser = ^{rx_tuser[TUSER_W-1:TUSER_BAR_MSB+1], rx_tuser[0]};

   // Route of the presented beat, input ready, and next FSM state.
   always_comb begin
      route     = ROUTE_DROP;
      sel_ready = 1'b1;
      state_d   = state_q;
      case (state_q)
         IDLE:    route = sop_route;
         FWD_REQ: route = ROUTE_REQ;
         FWD_CPL: route = ROUTE_CPL;
         default: route = ROUTE_DROP;
      endcase
      case (route)
         ROUTE_REQ: sel_ready = req_in_ready;
         ROUTE_CPL: sel_ready = cpl_in_ready;
         default:   sel_ready = 1'b1;
      endcase
      // run_q holds rx_tready low during reset, where drop-class beats would otherwise see 1.
      rx_tready = run_q && sel_ready;
      hs        = rx_tvalid && rx_tready;
      if (hs) begin
         if (state_q == IDLE) begin
            // A single-beat TLP never leaves IDLE.
            if (!rx_tlast) begin
               case (route)
                  ROUTE_REQ: state_d = FWD_REQ;
                  ROUTE_CPL: state_d = FWD_CPL;
                  default:   state_d = DROP;
               endcase
            end
         end else if (rx_tlast) begin
            state_d = IDLE;
         end
      end
   end

   // FSM state register and the out-of-reset flag.
   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   // BAR latch, unsupported-request strobe and saturating drop counter.
   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         bar_q        <= '0;
         ur_q         <= 1'b0;
         drop_count_q <= 16'd0;
      end else begin
         if (sop_accept) bar_q <= beat_bar;
         ur_q <= drop_sop && is_non_posted(rx_tdata[31:24]);
         if (drop_sop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
      end
   end

   assign ur_pulse   = ur_q;
   assign drop_count = drop_count_q;

   axis_skid_buf #(.WIDTH(REQ_W)) u_req_buf (
      .clk_i       (user_clk),
      .rst_i       (user_reset),
      .in_data_i   ({beat_bar, rx_tlast, rx_tkeep, rx_tdata}),
      .in_valid_i  (req_push),
      .in_ready_o  (req_in_ready),
      .out_data_o  (req_payload),
      .out_valid_o (req_tvalid),
      .out_ready_i (req_tready)
   );

   axis_skid_buf #(.WIDTH(CPL_W)) u_cpl_buf (
      .clk_i       (user_clk),
      .rst_i       (user_reset),
      .in_data_i   ({rx_tlast, rx_tkeep, rx_tdata}),
      .in_valid_i  (cpl_push),
      .in_ready_o  (cpl_in_ready),
      .out_data_o  (cpl_payload),
      .out_valid_o (cpl_tvalid),
      .out_ready_i (cpl_tready)
   );

   assign {req_bar, req_tlast, req_tkeep, req_tdata} = req_payload;
   assign {cpl_tlast, cpl_tkeep, cpl_tdata}          = cpl_payload;

endmodule

// File: tb/tb_pcie_rx_tlp_demux.sv
// Self-checking bench for pcie_rx_tlp_demux: a table of TLP classification
// vectors plus hand-written sequences for latency, back-pressure, throughput,
// counter saturation and mid-TLP reset.
module tb_pcie_rx_tlp_demux;

   localparam logic [1:0] R_REQ  = 2'd0;
   localparam logic [1:0] R_CPL  = 2'd1;
   localparam logic [1:0] R_DROP = 2'd2;

   typedef struct {
      logic [31:0] dw0;
      logic        err;
      logic [6:0]  bar;
      int          nbeats;
      logic [1:0]  route;
      int          ur;
   } vec_t;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic [6:0]  bar;
   } beat_t;

   logic        user_clk = 1'b0;
   logic        user_reset;
   logic [63:0] rx_tdata;
   logic [7:0]  rx_tkeep;
   logic        rx_tlast, rx_tvalid, rx_tready;
   logic [21:0] rx_tuser;
   logic [63:0] req_tdata, cpl_tdata;
   logic [7:0]  req_tkeep, cpl_tkeep;
   logic        req_tlast, req_tvalid, req_tready;
   logic        cpl_tlast, cpl_tvalid, cpl_tready;
   logic [6:0]  req_bar;
   logic        ur_pulse;
   logic [15:0] drop_count;

   int    checks   = 0;
   int    failures = 0;
   int    ur_cnt   = 0;
   beat_t mon_req[$], mon_cpl[$], exp_req[$], exp_cpl[$];

   always #5 user_clk = ~user_clk;

   pcie_rx_tlp_demux dut (
      .user_clk   (user_clk),
      .user_reset (user_reset),
      .rx_tdata   (rx_tdata),
      .rx_tkeep   (rx_tkeep),
      .rx_tlast   (rx_tlast),
      .rx_tvalid  (rx_tvalid),
      .rx_tready  (rx_tready),
      .rx_tuser   (rx_tuser),
      .req_tdata  (req_tdata),
      .req_tkeep  (req_tkeep),
      .req_tlast  (req_tlast),
      .req_tvalid (req_tvalid),
      .req_tready (req_tready),
      .req_bar    (req_bar),
      .cpl_tdata  (cpl_tdata),
      .cpl_tkeep  (cpl_tkeep),
      .cpl_tlast  (cpl_tlast),
      .cpl_tvalid (cpl_tvalid),
      .cpl_tready (cpl_tready),
      .ur_pulse   (ur_pulse),
      .drop_count (drop_count)
   );

   // Output monitor: records beats that will handshake at the next rising edge.
   always @(negedge user_clk) begin
      #2;
      if (req_tvalid && req_tready) mon_req.push_back('{req_tdata, req_tkeep, req_tlast, req_bar});
      if (cpl_tvalid && cpl_tready) mon_cpl.push_back('{cpl_tdata, cpl_tkeep, cpl_tlast, 7'h00});
      if (ur_pulse) ur_cnt++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] beat_data(input int idx, input int i, input logic [31:0] dw0);
      logic [7:0]  id8;
      logic [7:0]  i8;
      logic [31:0] lo;
      id8 = idx[7:0];
      i8  = i[7:0];
      lo  = 32'h1234_5600 + i;
      if (i == 0) return {16'hC0DE, id8, 8'h00, dw0};
      return {16'hBEEF, id8, i8, lo};
   endfunction

   function automatic logic [21:0] mk_user(input logic [6:0] bar, input logic err);
      return {13'h0, bar, err, 1'b0};
   endfunction

   // Present one beat from a falling edge; return at the falling edge after it is accepted.
   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [21:0] u, output bit ok);
      rx_tdata  = d;
      rx_tkeep  = k;
      rx_tlast  = l;
      rx_tuser  = u;
      rx_tvalid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         #1;
         if (rx_tready) ok = 1'b1;
         @(negedge user_clk);
      end
   endtask

   task automatic send_tlp(input vec_t v, input int idx);
      bit    ok;
      beat_t b;
      for (int i = 0; i < v.nbeats; i++) begin
         b.d   = beat_data(idx, i, v.dw0);
         b.l   = (i == v.nbeats - 1);
         b.k   = b.l ? 8'h0F : 8'hFF;
         b.bar = (v.route == R_REQ) ? v.bar : 7'h00;
         if (v.route == R_REQ) exp_req.push_back(b);
         else if (v.route == R_CPL) exp_cpl.push_back(b);
         send_beat(b.d, b.k, b.l, mk_user(v.bar, v.err), ok);
         check($sformatf("accept tlp%0d beat%0d", idx, i), {63'd0, ok}, 64'd1);
      end
      rx_tvalid = 1'b0;
   endtask

   task automatic compare_outputs(input string tag);
      check({tag, " req_beats"}, mon_req.size(), exp_req.size());
      for (int i = 0; i < mon_req.size() && i < exp_req.size(); i++) begin
         check($sformatf("%s req_data[%0d]", tag, i), mon_req[i].d, exp_req[i].d);
         check($sformatf("%s req_side[%0d]", tag, i), {mon_req[i].k, mon_req[i].l, mon_req[i].bar},
               {exp_req[i].k, exp_req[i].l, exp_req[i].bar});
      end
      check({tag, " cpl_beats"}, mon_cpl.size(), exp_cpl.size());
      for (int i = 0; i < mon_cpl.size() && i < exp_cpl.size(); i++) begin
         check($sformatf("%s cpl_data[%0d]", tag, i), mon_cpl[i].d, exp_cpl[i].d);
         check($sformatf("%s cpl_side[%0d]", tag, i), {mon_cpl[i].k, mon_cpl[i].l},
               {exp_cpl[i].k, exp_cpl[i].l});
      end
      mon_req.delete();
      mon_cpl.delete();
      exp_req.delete();
      exp_cpl.delete();
   endtask

   initial begin
      vec_t vecs[13];
      vec_t v;
      bit   ok;
      int   exp_drop;
      int   ur_before;
      time  t0;

      vecs[0]  = '{32'h0000_0001, 1'b0, 7'h01, 2, R_REQ,  0}; // MemRd32
      vecs[1]  = '{32'h2000_0002, 1'b0, 7'h04, 1, R_REQ,  0}; // MemRd64, single beat
      vecs[2]  = '{32'h4000_0001, 1'b0, 7'h02, 3, R_REQ,  0}; // MemWr32
      vecs[3]  = '{32'h6000_0002, 1'b0, 7'h10, 4, R_REQ,  0}; // MemWr64
      vecs[4]  = '{32'h0A00_0000, 1'b0, 7'h00, 2, R_CPL,  0}; // Cpl
      vecs[5]  = '{32'h4A00_0004, 1'b0, 7'h00, 4, R_CPL,  0}; // CplD
      vecs[6]  = '{32'h0200_0001, 1'b0, 7'h00, 2, R_DROP, 1}; // IORd
      vecs[7]  = '{32'h3000_0000, 1'b0, 7'h00, 2, R_DROP, 0}; // Msg (posted)
      vecs[8]  = '{32'h4000_0001, 1'b1, 7'h01, 3, R_DROP, 0}; // poisoned MemWr32
      vecs[9]  = '{32'h0400_0001, 1'b0, 7'h00, 2, R_DROP, 1}; // CfgRd0
      vecs[10] = '{32'h7000_0001, 1'b0, 7'h00, 3, R_DROP, 0}; // MsgD
      vecs[11] = '{32'h0B00_0000, 1'b0, 7'h00, 1, R_DROP, 1}; // CplLk, single beat
      vecs[12] = '{32'h0000_0001, 1'b1, 7'h02, 2, R_DROP, 1}; // poisoned MemRd32

      // Reset state, with a drop-class beat presented to expose an ungated ready.
      user_reset = 1'b1;
      rx_tdata   = {32'h0, 32'h0200_0001};
      rx_tkeep   = 8'hFF;
      rx_tlast   = 1'b1;
      rx_tuser   = 22'h0;
      rx_tvalid  = 1'b1;
      req_tready = 1'b1;
      cpl_tready = 1'b1;
      repeat (3) @(negedge user_clk);
      #1;
      check("reset rx_tready", rx_tready, 0);
      check("reset req_tvalid", req_tvalid, 0);
      check("reset cpl_tvalid", cpl_tvalid, 0);
      check("reset ur_pulse", ur_pulse, 0);
      check("reset drop_count", drop_count, 0);
      check("reset req_tdata", req_tdata, 0);
      check("reset cpl_tdata", cpl_tdata, 0);
      rx_tvalid = 1'b0;
      @(negedge user_clk);
      user_reset = 1'b0;
      @(negedge user_clk);

      // One-cycle latency on REQ with the BAR held across both beats.
      send_beat(beat_data(100, 0, 32'h0000_0001), 8'hFF, 1'b0, mk_user(7'h01, 1'b0), ok);
      check("lat accept0", {63'd0, ok}, 1);
      check("lat req_tvalid", req_tvalid, 1);
      check("lat req_tdata0", req_tdata, beat_data(100, 0, 32'h0000_0001));
      check("lat req_bar0", req_bar, 7'h01);
      check("lat cpl_tvalid", cpl_tvalid, 0);
      send_beat(beat_data(100, 1, 32'h0000_0001), 8'h0F, 1'b1, mk_user(7'h00, 1'b0), ok);
      rx_tvalid = 1'b0;
      check("lat accept1", {63'd0, ok}, 1);
      check("lat req_tdata1", req_tdata, beat_data(100, 1, 32'h0000_0001));
      check("lat req_side1", {req_tkeep, req_tlast, req_bar}, {8'h0F, 1'b1, 7'h01});
      repeat (3) @(negedge user_clk);
      check("lat drop_count", drop_count, 0);
      mon_req.delete();
      mon_cpl.delete();

      // Classification table.
      exp_drop = 0;
      for (int i = 0; i < 13; i++) begin
         ur_before = ur_cnt;
         send_tlp(vecs[i], i);
         repeat (4) @(negedge user_clk);
         if (vecs[i].route == R_DROP) exp_drop++;
         compare_outputs($sformatf("vec%0d", i));
         check($sformatf("vec%0d ur_cycles", i), ur_cnt - ur_before, vecs[i].ur);
         check($sformatf("vec%0d drop_count", i), drop_count, exp_drop);
      end

      // Back-to-back MemWr64 then Cpl at one beat per cycle.
      t0 = $time;
      v = '{32'h6000_0003, 1'b0, 7'h08, 3, R_REQ, 0};
      send_tlp(v, 20);
      v = '{32'h0A00_0000, 1'b0, 7'h00, 2, R_CPL, 0};
      send_tlp(v, 21);
      check("b2b cycles", (($time - t0) / 10), 5);
      repeat (4) @(negedge user_clk);
      compare_outputs("b2b");

      // CplD against a stalled CPL port: input stops after two buffered beats.
      cpl_tready = 1'b0;
      v = '{32'h4A00_0004, 1'b0, 7'h00, 4, R_CPL, 0};
      fork
         send_tlp(v, 30);
         begin
            repeat (3) @(negedge user_clk);
            #1;
            check("stall rx_tready", rx_tready, 0);
            check("stall cpl_tvalid", cpl_tvalid, 1);
            check("stall cpl_tdata", cpl_tdata, beat_data(30, 0, 32'h4A00_0004));
            repeat (2) @(negedge user_clk);
            cpl_tready = 1'b1;
         end
      join
      repeat (5) @(negedge user_clk);
      compare_outputs("stall");

      // Drop counter saturation.
      force dut.drop_count_q = 16'hFFFE;
      #1;
      release dut.drop_count_q;
      @(negedge user_clk);
      check("sat preload", drop_count, 16'hFFFE);
      v = '{32'h0200_0001, 1'b0, 7'h00, 1, R_DROP, 1};
      send_tlp(v, 40);
      @(negedge user_clk);
      check("sat first", drop_count, 16'hFFFF);
      send_tlp(v, 41);
      send_tlp(v, 42);
      @(negedge user_clk);
      check("sat held", drop_count, 16'hFFFF);

      // Reset in the middle of a CplD with two beats parked in the CPL buffer.
      cpl_tready = 1'b0;
      send_beat(beat_data(50, 0, 32'h4A00_0004), 8'hFF, 1'b0, mk_user(7'h00, 1'b0), ok);
      send_beat(beat_data(50, 1, 32'h4A00_0004), 8'hFF, 1'b0, mk_user(7'h00, 1'b0), ok);
      check("mid cpl_tvalid before", cpl_tvalid, 1);
      user_reset = 1'b1;
      rx_tvalid  = 1'b0;
      #1;
      check("mid cpl_tvalid", cpl_tvalid, 0);
      check("mid req_tvalid", req_tvalid, 0);
      check("mid rx_tready", rx_tready, 0);
      check("mid drop_count", drop_count, 0);
      repeat (2) @(negedge user_clk);
      user_reset = 1'b0;
      cpl_tready = 1'b1;
      mon_req.delete();
      mon_cpl.delete();
      @(negedge user_clk);
      v = '{32'h0000_0001, 1'b0, 7'h40, 2, R_REQ, 0};
      send_tlp(v, 51);
      repeat (4) @(negedge user_clk);
      compare_outputs("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
